// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the uart_tx byte buffer/dispatcher: data width and dispatcher states.
package uart_tx_fifo_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } disp_state_t;

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Synchronous byte FIFO with registered count/full/empty flags and a one-cycle overflow pulse.
module uart_tx_fifo_byte_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   rd_en,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   overflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr;
    logic [ADDR_W-1:0]      rd_ptr;
    logic [ADDR_W:0]        count_next;
    logic                   wr_ok;
    logic                   rd_ok;

    // Accept/pop decisions use the registered flags, so a pop at full never frees room the same cycle.
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: the storage array is deliberately not reset; only pointers and flags define its validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            full     <= (count_next == FULL_COUNT);
            empty    <= (count_next == '0);
            overflow <= wr_en && full;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer feeding uart_tx: FIFO plus a dispatcher that launches one byte per idle uart_tx frame.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr_en,
    input  logic [UART_DATA_W-1:0] i_wr_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [ADDR_W:0]        o_count,
    output logic                   o_overflow,
    output logic                   o_tx_start,
    output logic [UART_DATA_W-1:0] o_tx_data,
    input  logic                   i_tx_busy
);

    disp_state_t            state;
    disp_state_t            state_next;
    logic                   pop;
    logic                   tx_start_next;
    logic [UART_DATA_W-1:0] tx_data_next;
    logic [UART_DATA_W-1:0] head;

    uart_tx_fifo_byte_fifo #(
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (i_wr_en),
        .wr_data  (i_wr_data),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (o_full),
        .empty    (o_empty),
        .count    (o_count),
        .overflow (o_overflow)
    );

    // The busy guard in IDLE also protects a uart_tx that kept transmitting through our reset.
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        tx_start_next = 1'b0;
        tx_data_next  = o_tx_data;
        case (state)
            S_IDLE: begin
                if (!o_empty && !i_tx_busy) begin
                    pop           = 1'b1;
                    tx_start_next = 1'b1;
                    tx_data_next  = head;
                    state_next    = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            state      <= state_next;
            o_tx_start <= tx_start_next;
            o_tx_data  <= tx_data_next;
        end
    end

endmodule
